gcd_stein: RTL and testbench
============================

# gcd_stein

Parametrised, iterative binary (Stein's algorithm) greatest-common-divisor unit. It succeeds the fixed 32-bit subtract-based GCD block. It keeps the same start/busy/valid handshake so existing bench drivers can reuse it. It adds a configurable operand width, zero-operand handling, a coprime flag, and a bounded worst-case latency. It sits as a standalone arithmetic accelerator behind a simple request/response controller.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start_i  in  1  request strobe; sampled on rising edge only when busy_o = 0
- a_i  in  WIDTH  operand A, unsigned; sampled with accepted start_i
- b_i  in  WIDTH  operand B, unsigned; sampled with accepted start_i
- busy_o  out  1  high while a computation is in progress
- valid_o  out  1  high from completion until the next accepted start
- result_o  out  WIDTH  gcd(A,B); stable while valid_o = 1
- coprime_o  out  1  valid_o & (result_o == 1)
- cycles_o  out  WIDTH  iteration count of last computation (only with GCD_CYCLES_EN)

## Operation
- Registers: x, y (WIDTH), k shift count ($clog2(WIDTH)+1 bits), state.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 latches x←a_i, y←b_i, k←0, clears valid_o, then goes to CALC.
  - start_i=0 stays in IDLE.
- CALC performs one step per cycle, in priority order:
  - x==0: result←y<<k, go to DONE.
  - y==0: result←x<<k, go to DONE.
  - x, y both even: x>>=1, y>>=1, k++.
  - x even only: x>>=1.
  - y even only: y>>=1.
  - both odd, x≥y: x←(x−y)>>1.
  - both odd, x<y: y←(y−x)>>1.
- DONE: assert valid_o, drive result_o, return to IDLE on the next cycle. valid_o and result_o stay held.
- Zero rules: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0. None of these is an error.
- The shift result<<k never overflows WIDTH, because gcd ≤ max(A,B). Subtractions are unsigned and never underflow, because they are guarded by the comparison.
- start_i while busy_o=1 is ignored; no queueing.
- start_i in the same cycle DONE returns to IDLE is not accepted. It is accepted from the IDLE cycle onward.

## Timing
- Reset values: busy_o=0, valid_o=0, result_o=0, coprime_o=0, cycles_o=0, state=IDLE.
- Start accepted at edge N; busy_o=1 and valid_o=0 from edge N.
- Each CALC step takes 1 cycle. With S steps (including the terminating zero-detect step), valid_o rises at edge N+S+1 and busy_o falls at the same edge.
- Worst case: S ≤ 2·WIDTH+1, so a WIDTH=32 request completes within 66 cycles of acceptance.
- Minimum: an operand of 0 gives S=1, with valid_o at edge N+2.
- Reset mid-operation: all outputs drop to their reset values asynchronously. The in-flight request is discarded and no valid_o is produced.
- Inputs a_i/b_i may change freely after acceptance.

## Configuration
- GCD_CYCLES_EN defined:
  - cycles_o port exists.
  - The counter clears on accepted start and increments once per CALC step.
  - It holds its value alongside result_o.
- GCD_CYCLES_EN undefined:
  - cycles_o port and counter are absent.
  - All other behaviour is identical.

## Test plan
- A=48, B=18 → result_o=6, coprime_o=0; valid_o within 2·WIDTH+2 cycles of start.
- A=17, B=13 → result_o=1, coprime_o=1.
- A=0, B=35 → result_o=35 at N+2; A=0, B=0 → result_o=0, valid_o still asserted.
- WIDTH=32, A=0x80000000, B=0x40000000 → result_o=0x40000000. A=B=0xFFFFFFFF → result_o=0xFFFFFFFF. Both must complete within 66 cycles.
- While computing gcd(48,18), pulse start_i with A=7, B=5 → the pulse is ignored and result_o=6. A later start with the same values → result_o=1.
- Assert reset 3 cycles into gcd(1071,462), release it, then start gcd(1071,462) → no valid_o before the restart, then result_o=21. With GCD_CYCLES_EN, cycles_o equals the bench model's step count.

Source files
------------

// File: rtl/gcd_stein_if.sv
// Request/response bundle for the gcd_stein accelerator.
// bus.o_cycles exists only when GCD_CYCLES_EN is defined.
interface gcd_stein_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic             o_coprime;
`ifdef GCD_CYCLES_EN
  logic [WIDTH-1:0] o_cycles;
`endif

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_valid, o_result, o_coprime
`ifdef GCD_CYCLES_EN
    , o_cycles
`endif
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_valid, o_result, o_coprime
`ifdef GCD_CYCLES_EN
    , o_cycles
`endif
  );
endinterface

// File: rtl/gcd_stein.sv
// Iterative binary (Stein) GCD unit with start/busy/valid handshake.
// Define GCD_CYCLES_EN to expose the per-request step counter on bus.o_cycles.
//
// state | meaning
// IDLE  | waiting for start; result/valid of last request held
// CALC  | one Stein reduction step per cycle
// DONE  | result captured; valid rises on the transition back to IDLE
module gcd_stein #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  gcd_stein_if.slave bus
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_busy;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;

  logic             w_accept;
  logic             w_x_zero;
  logic             w_y_zero;
  logic             w_x_even;
  logic             w_y_even;
  logic             w_x_ge_y;
  logic [WIDTH-1:0] w_x_minus_y;
  logic [WIDTH-1:0] w_y_minus_x;

  assign w_accept    = (r_state == S_IDLE) && bus.i_start;
  assign w_x_zero    = (r_x == '0);
  assign w_y_zero    = (r_y == '0);
  assign w_x_even    = ~r_x[0];
  assign w_y_even    = ~r_y[0];
  assign w_x_ge_y    = (r_x >= r_y);
  assign w_x_minus_y = r_x - r_y;
  assign w_y_minus_x = r_y - r_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_next_state = S_CALC;
      S_CALC:  if (w_x_zero || w_y_zero) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // DONE still counts as busy so a start coinciding with the return to IDLE is dropped.
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_x     <= bus.i_a;
            r_y     <= bus.i_b;
            r_k     <= '0;
            r_valid <= 1'b0;
          end
        end
        S_CALC: begin
          // gcd <= max(A,B), so the final shift by k cannot overflow.
          if (w_x_zero) begin
            r_result <= r_y << r_k;
          end else if (w_y_zero) begin
            r_result <= r_x << r_k;
          end else if (w_x_even && w_y_even) begin
            r_x <= r_x >> 1;
            r_y <= r_y >> 1;
            r_k <= r_k + KW'(1);
          end else if (w_x_even) begin
            r_x <= r_x >> 1;
          end else if (w_y_even) begin
            r_y <= r_y >> 1;
          end else if (w_x_ge_y) begin
            r_x <= w_x_minus_y >> 1;
          end else begin
            r_y <= w_y_minus_x >> 1;
          end
        end
        S_DONE: begin
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_CYCLES_EN
  logic [WIDTH-1:0] r_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_cycles <= '0;
    else if (w_accept)          r_cycles <= '0;
    else if (r_state == S_CALC) r_cycles <= r_cycles + WIDTH'(1);
  end

  assign bus.o_cycles = r_cycles;
`endif

  assign bus.o_busy    = w_busy;
  assign bus.o_valid   = r_valid;
  assign bus.o_result  = r_result;
  assign bus.o_coprime = r_valid && (r_result == WIDTH'(1));

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein: Euclid reference plus a cycle-level handshake model.
// Directed cases pin literal results; randomized requests exercise the rest.
module tb_gcd_stein;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  gcd_stein_if #(.WIDTH(W)) bus ();

  gcd_stein #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference GCD by Euclid's remainder method.
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of Stein steps the algorithm takes, counting the terminating zero test.
  function automatic int stein_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    int n;
    x = a;
    y = b;
    n = 0;
    for (int guard = 0; guard < 4 * W; guard++) begin
      n = n + 1;
      if (x == 0 || y == 0) break;
      if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2;
        y = y / 2;
      end else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x >= y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
    return n;
  endfunction

  // Handshake model: accepted start -> busy for steps+1 edges, then valid with result.
  logic         m_busy, m_valid;
  logic [W-1:0] m_result, m_pend;
  int           m_cnt, m_steps, m_cycles;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_result <= '0;
      m_pend   <= '0;
      m_cnt    <= 0;
      m_steps  <= 0;
      m_cycles <= 0;
    end else if (!m_busy) begin
      if (bus.i_start) begin
        m_busy  <= 1'b1;
        m_valid <= 1'b0;
        m_cnt   <= stein_steps(bus.i_a, bus.i_b);
        m_steps <= stein_steps(bus.i_a, bus.i_b);
        m_pend  <= gcd_ref(bus.i_a, bus.i_b);
      end
    end else if (m_cnt == 0) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b1;
      m_result <= m_pend;
      m_cycles <= m_steps;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", W'(bus.o_busy), W'(m_busy));
    chk("valid", W'(bus.o_valid), W'(m_valid));
    chk("coprime", W'(bus.o_coprime), W'(m_valid && (m_result == 1)));
    if (!m_busy) begin
      chk("result", bus.o_result, m_result);
`ifdef GCD_CYCLES_EN
      chk("cycles", bus.o_cycles, W'(m_cycles));
`endif
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit use_lit, input logic [W-1:0] lit, input bit lit_cop);
    int lat;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
    lat = 0;
    for (int i = 0; i < 2 * W + 4 && !bus.o_valid; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!bus.o_valid) begin
      errors++;
      $display("FAIL timeout a=%0h b=%0h actual_valid=0 required_valid=1", a, b);
    end
    checks++;
    if (lat > 2 * W + 2) begin
      errors++;
      $display("FAIL latency a=%0h b=%0h actual=%0d required<=%0d", a, b, lat, 2 * W + 2);
    end
    if (use_lit) begin
      chk("lit_result", bus.o_result, lit);
      chk("lit_coprime", W'(bus.o_coprime), W'(lit_cop));
    end
  endtask

  initial begin
    logic [W-1:0] a, b, g;
    int lat;
    reset       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", bus.o_result, '0);
    chk("reset_valid", W'(bus.o_valid), '0);
    reset = 1'b0;

    do_op(48, 18, 1, 6, 0);
    do_op(17, 13, 1, 1, 1);
    do_op(0, 35, 1, 35, 0);
    do_op(0, 0, 1, 0, 0);
    do_op(35, 0, 1, 35, 0);
    do_op(32'h8000_0000, 32'h4000_0000, 1, 32'h4000_0000, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
    do_op(1, 32'hFFFF_FFFF, 1, 1, 1);

    // Minimum latency: zero operand -> valid exactly two edges after acceptance.
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_a = 0; bus.i_b = 99;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && !bus.o_valid; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("min_latency", W'(lat), 2);

    // A start pulse during computation is ignored.
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_a = 48; bus.i_b = 18;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.i_start = 1'b1; bus.i_a = 7; bus.i_b = 5;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int i = 0; i < 2 * W + 4 && !bus.o_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("ignored_start", bus.o_result, 6);
    do_op(7, 5, 1, 1, 1);

    // Reset three cycles into a request; nothing must complete until the restart.
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_a = 1071; bus.i_b = 462;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_busy", W'(bus.o_busy), '0);
    chk("rst_valid", W'(bus.o_valid), '0);
    chk("rst_result", bus.o_result, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    do_op(1071, 462, 1, 21, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin
          g = W'($urandom_range(1, 255)) << $urandom_range(0, 8);
          a = g * W'($urandom_range(0, 1000));
          b = g * W'($urandom_range(0, 1000));
        end
        2: begin
          a = $urandom;
          b = $urandom;
          if ($urandom_range(0, 1) == 1) a = '0;
          else b = '0;
        end
        default: begin a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15)); end
      endcase
      do_op(a, b, 1, gcd_ref(a, b), gcd_ref(a, b) == 1);
    end

    // Start held high with operands changing every cycle: back-to-back requests.
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b1;
      bus.i_a     = W'($urandom_range(0, 4095));
      bus.i_b     = W'($urandom_range(0, 4095));
    end
    bus.i_start = 1'b0;
    for (int i = 0; i < 2 * W + 4 && m_busy; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
